// File: rtl/output_spad_writer_if.sv
// Router-to-SPAD write bundle for output_spad_writer.
// OSW_STALL_CNT_EN adds the o_stall_cycles status bus.
interface output_spad_writer_if #(
  parameter int AW = 8,
  parameter int DW = 16
);
  logic          i_start;
  logic [AW-1:0] i_base_addr;
  logic [AW:0]   i_num_words;
  logic [DW-1:0] i_data;
  logic          i_valid;
  logic          i_wr_ready;
  logic          o_wr_en;
  logic [AW-1:0] o_wr_addr;
  logic [DW-1:0] o_wr_data;
  logic          o_busy;
  logic          o_done;
  logic          o_overflow;
`ifdef OSW_STALL_CNT_EN
  logic [15:0]   o_stall_cycles;
`endif

  modport slave (
    input  i_start, i_base_addr, i_num_words,
    input  i_data, i_valid, i_wr_ready,
    output o_wr_en, o_wr_addr, o_wr_data,
`ifdef OSW_STALL_CNT_EN
    output o_stall_cycles,
`endif
    output o_busy, o_done, o_overflow
  );

  modport master (
    output i_start, i_base_addr, i_num_words,
    output i_data, i_valid, i_wr_ready,
    input  o_wr_en, o_wr_addr, o_wr_data,
`ifdef OSW_STALL_CNT_EN
    input  o_stall_cycles,
`endif
    input  o_busy, o_done, o_overflow
  );
endinterface

// File: rtl/output_spad_writer.sv
// Buffers router words in a skid FIFO and writes them to the output SPAD.
// OSW_STALL_CNT_EN adds a saturating write-stall cycle counter.
module output_spad_writer #(
  parameter int SPAD_ADDR_WIDTH = 8,
  parameter int SPAD_DATA_WIDTH = 16,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  output_spad_writer_if.slave  bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int AW = SPAD_ADDR_WIDTH;
  localparam int DW = SPAD_DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] mem_q [FIFO_DEPTH];
  logic [DW-1:0] mem_d [FIFO_DEPTH];
  logic [PW:0]   wptr_q, wptr_d;
  logic [PW:0]   rptr_q, rptr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   num_q, num_d;
  logic [AW:0]   acc_q, acc_d;
  logic          ovf_q, ovf_d;
`ifdef OSW_STALL_CNT_EN
  logic [15:0]   stall_q, stall_d;
`endif

  logic empty, full, active, push, pop;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty  = (wptr_q == rptr_q);
  assign full   = (wptr_q[PW] != rptr_q[PW]) &&
                  (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign active = (state_q == RUN) || (state_q == DRAIN);
  assign pop    = !empty && bus.i_wr_ready && active;
  assign push   = (state_q == RUN) && bus.i_valid && (!full || pop);

  assign bus.o_wr_en    = pop;
  assign bus.o_wr_addr  = addr_q;
  assign bus.o_wr_data  = mem_q[rptr_q[PW-1:0]];
  assign bus.o_busy     = (state_q != IDLE);
  assign bus.o_done     = (state_q == DONE);
  assign bus.o_overflow = ovf_q;
`ifdef OSW_STALL_CNT_EN
  assign bus.o_stall_cycles = stall_q;
`endif

  always_comb begin
    state_d = state_q;
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    addr_d  = addr_q;
    num_d   = num_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
`ifdef OSW_STALL_CNT_EN
    stall_d = stall_q;
    if (active && !empty && !bus.i_wr_ready && stall_q != 16'hFFFF)
      stall_d = stall_q + 16'd1;
`endif
    if (push) begin
      mem_d[wptr_q[PW-1:0]] = bus.i_data;
      wptr_d = wptr_q + (PW+1)'(1);
      acc_d  = acc_q + (AW+1)'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + (PW+1)'(1);
      addr_d = addr_q + AW'(1);
    end
    if (bus.i_valid && !push && active)
      ovf_d = 1'b1;
    unique case (state_q)
      IDLE: if (bus.i_start) begin
        addr_d  = bus.i_base_addr;
        num_d   = bus.i_num_words;
        acc_d   = '0;
        wptr_d  = '0;
        rptr_d  = '0;
        ovf_d   = 1'b0;
`ifdef OSW_STALL_CNT_EN
        stall_d = '0;
`endif
        state_d = (bus.i_num_words == '0) ? DONE : RUN;
      end
      RUN:
        if (push && (acc_q + (AW+1)'(1) == num_q))
          state_d = DRAIN;
      DRAIN: if (empty) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      addr_q  <= '0;
      num_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
`ifdef OSW_STALL_CNT_EN
      stall_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      addr_q  <= addr_d;
      num_q   <= num_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
`ifdef OSW_STALL_CNT_EN
      stall_q <= stall_d;
`endif
    end
  end
endmodule
